// File: rtl/test_pattern_pkg.sv
// rtl/test_pattern_pkg.sv - pattern mode encoding and colour-bar flag table for hdmi_test_pattern
package test_pattern_pkg;

  typedef enum logic [2:0] {
    MODE_BORDER  = 3'd0,
    MODE_BARS    = 3'd1,
    MODE_CHECKER = 3'd2,
    MODE_RAMP    = 3'd3,
    MODE_SOLID   = 3'd4,
    MODE_BLACK   = 3'd5
  } mode_t;

  // {R,G,B} on/off flags per bar, bar 0 leftmost
  function automatic logic [2:0] bar_flags(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_flags = 3'b111;
      3'd1:    bar_flags = 3'b110;
      3'd2:    bar_flags = 3'b011;
      3'd3:    bar_flags = 3'b010;
      3'd4:    bar_flags = 3'b101;
      3'd5:    bar_flags = 3'b100;
      3'd6:    bar_flags = 3'b001;
      default: bar_flags = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/hdmi_test_pattern_bar_counter.sv
// rtl/hdmi_test_pattern_bar_counter.sv - per-line pixel counter producing the colour-bar index
module hdmi_test_pattern_bar_counter #(
  parameter int BIT_WIDTH = 10,
  parameter int BAR_LOG2  = 3
) (
  input  logic                 i_clk_pixel,
  input  logic                 i_reset,
  input  logic [BIT_WIDTH-1:0] i_rx,
  input  logic                 i_active,
  input  logic [BIT_WIDTH-1:0] i_bar_width,
  output logic [BAR_LOG2-1:0]  o_bar_idx
);

  localparam logic [BAR_LOG2-1:0] LAST_BAR = '1;

  logic [BIT_WIDTH-1:0] r_count;
  logic [BAR_LOG2-1:0]  r_bar;
  logic [BAR_LOG2-1:0]  r_bar_idx;

  logic                 w_first;
  logic                 w_wrap;
  logic [BIT_WIDTH-1:0] w_cnt;
  logic [BAR_LOG2-1:0]  w_bar;

  // r_count/r_bar describe the next pixel; the first active pixel of a line restarts them
  assign w_first = (i_rx == '0);
  assign w_cnt   = w_first ? '0 : r_count;
  assign w_bar   = w_first ? '0 : r_bar;
  assign w_wrap  = (w_cnt == i_bar_width - BIT_WIDTH'(1));

  always_ff @(posedge i_clk_pixel) begin
    if (i_reset) begin
      r_count   <= '0;
      r_bar     <= '0;
      r_bar_idx <= '0;
    end else begin
      r_bar_idx <= i_active ? w_bar : '0;
      if (i_active) begin
        if (w_wrap && (w_bar != LAST_BAR)) begin
          r_count <= '0;
          r_bar   <= w_bar + BAR_LOG2'(1);
        end else begin
          r_count <= w_wrap ? w_cnt : w_cnt + BIT_WIDTH'(1);
          r_bar   <= w_bar;
        end
      end
    end
  end

  assign o_bar_idx = r_bar_idx;

endmodule

// File: rtl/hdmi_test_pattern.sv
// rtl/hdmi_test_pattern.sv - two-stage registered test-pattern pixel source for the hdmi core
// HDMI_TEST_PATTERN_ANIMATE_EN: frame counter runs and scrolls checker/ramp by one pixel per frame
module hdmi_test_pattern
  import test_pattern_pkg::*;
#(
  parameter int BIT_WIDTH    = 10,
  parameter int BIT_HEIGHT   = 10,
  parameter int COLOR_DEPTH  = 8,
  parameter int BAR_LOG2     = 3,
  parameter int CHECKER_LOG2 = 5
) (
  input  logic                     clk_pixel,
  input  logic                     reset,
  input  logic [BIT_WIDTH-1:0]     cx,
  input  logic [BIT_HEIGHT-1:0]    cy,
  input  logic [BIT_WIDTH-1:0]     screen_start_x,
  input  logic [BIT_HEIGHT-1:0]    screen_start_y,
  input  logic [BIT_WIDTH-1:0]     screen_width,
  input  logic [BIT_HEIGHT-1:0]    screen_height,
  input  logic [2:0]               mode,
  input  logic [3*COLOR_DEPTH-1:0] solid_rgb,
  output logic [3*COLOR_DEPTH-1:0] rgb,
  output logic [2:0]               mode_active,
  output logic [7:0]               frame_count
);

  logic                     w_frame_start;
  logic [2:0]               w_mode_req;
  logic [2:0]               w_mode_eff;
  logic [BIT_WIDTH-1:0]     w_rx;
  logic [BIT_WIDTH-1:0]     w_x_end;
  logic [BIT_WIDTH-1:0]     w_bar_width;
  logic [BIT_WIDTH-1:0]     w_rx_anim;
  logic [BIT_HEIGHT-1:0]    w_ry;
  logic [BIT_HEIGHT-1:0]    w_y_end;
  logic                     w_active;
  logic [7:0]               w_frame_eff;
  logic [BAR_LOG2-1:0]      w_s1_bar;
  logic [3*COLOR_DEPTH-1:0] w_pix;

  logic [2:0]               r_mode_active;
  logic [2:0]               r_s1_mode;
  logic                     r_s1_active;
  logic                     r_s1_chk;
  logic [BIT_WIDTH-1:0]     r_s1_rx;
  logic [BIT_HEIGHT-1:0]    r_s1_ry;
  logic [COLOR_DEPTH-1:0]   r_s1_ramp;
  logic [3*COLOR_DEPTH-1:0] r_s1_solid;
  logic [3*COLOR_DEPTH-1:0] r_rgb;

  function automatic logic [3*COLOR_DEPTH-1:0] expand(input logic [2:0] f);
    return {{COLOR_DEPTH{f[2]}}, {COLOR_DEPTH{f[1]}}, {COLOR_DEPTH{f[0]}}};
  endfunction

  assign w_frame_start = (cx == '0) && (cy == '0);
  assign w_mode_req    = (mode > MODE_SOLID) ? MODE_BLACK : mode;
  // the frame-start pixel already belongs to the new frame's mode
  assign w_mode_eff    = w_frame_start ? w_mode_req : r_mode_active;

  assign w_rx        = cx - screen_start_x;
  assign w_ry        = cy - screen_start_y;
  assign w_x_end     = screen_start_x + screen_width;
  assign w_y_end     = screen_start_y + screen_height;
  assign w_active    = (cx >= screen_start_x) && (cx < w_x_end) &&
                       (cy >= screen_start_y) && (cy < w_y_end);
  assign w_bar_width = screen_width >> BAR_LOG2;
  assign w_rx_anim   = w_rx + BIT_WIDTH'(w_frame_eff);

`ifdef HDMI_TEST_PATTERN_ANIMATE_EN
  logic [7:0] r_frame_count;

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      r_frame_count <= '0;
    end else if (w_frame_start) begin
      r_frame_count <= r_frame_count + 8'd1;
    end
  end

  assign w_frame_eff = w_frame_start ? r_frame_count + 8'd1 : r_frame_count;
  assign frame_count = r_frame_count;
`else
  assign w_frame_eff = '0;
  assign frame_count = '0;
`endif

  hdmi_test_pattern_bar_counter #(
    .BIT_WIDTH (BIT_WIDTH),
    .BAR_LOG2  (BAR_LOG2)
  ) u_bar_counter (
    .i_clk_pixel (clk_pixel),
    .i_reset     (reset),
    .i_rx        (w_rx),
    .i_active    (w_active),
    .i_bar_width (w_bar_width),
    .o_bar_idx   (w_s1_bar)
  );

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      r_mode_active <= MODE_BORDER;
      r_s1_mode     <= MODE_BORDER;
      r_s1_active   <= 1'b0;
      r_s1_chk      <= 1'b0;
      r_s1_rx       <= '0;
      r_s1_ry       <= '0;
      r_s1_ramp     <= '0;
      r_s1_solid    <= '0;
    end else begin
      if (w_frame_start) begin
        r_mode_active <= w_mode_req;
      end
      r_s1_mode   <= w_mode_eff;
      r_s1_active <= w_active;
      r_s1_chk    <= w_rx_anim[CHECKER_LOG2] ^ w_ry[CHECKER_LOG2];
      r_s1_rx     <= w_rx;
      r_s1_ry     <= w_ry;
      r_s1_ramp   <= COLOR_DEPTH'(w_rx_anim);
      r_s1_solid  <= solid_rgb;
    end
  end

  always_comb begin
    w_pix = '0;
    if (r_s1_active) begin
      case (r_s1_mode)
        MODE_BORDER:  w_pix = expand({r_s1_rx == '0, r_s1_ry == '0,
                                      (r_s1_rx == screen_width - BIT_WIDTH'(1)) ||
                                      (r_s1_ry == screen_height - BIT_HEIGHT'(1))});
        MODE_BARS:    w_pix = expand(bar_flags(3'(w_s1_bar)));
        MODE_CHECKER: w_pix = expand({3{r_s1_chk}});
        MODE_RAMP:    w_pix = {3{r_s1_ramp}};
        MODE_SOLID:   w_pix = r_s1_solid;
        default:      w_pix = '0;
      endcase
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      r_rgb <= '0;
    end else begin
      r_rgb <= w_pix;
    end
  end

  assign rgb         = r_rgb;
  assign mode_active = r_mode_active;

endmodule
